// File: rtl/unidad_de_busqueda.sv
// Instruction fetch unit: requests words from instruction memory at o_PC,
// hands them to the instruction register with a one-cycle strobe and handles jumps, halts and timeouts.
module unidad_de_busqueda #(
  parameter int MAX_ESPERA = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [8:0] i_Mem_dato,
  input  logic       i_Mem_ack,
  input  logic       i_Salto,
  input  logic [7:0] i_Dir_salto,
  input  logic       i_Detener,
  output logic       o_Mem_req,
  output logic [7:0] o_Mem_dir,
  output logic [8:0] o_Instruccion,
  output logic       o_Timming,
  output logic [7:0] o_PC,
  output logic       o_Error
);
  localparam logic [2:0] REPOSO   = 3'd0;
  localparam logic [2:0] SOLICITA = 3'd1;
  localparam logic [2:0] ENTREGA  = 3'd2;
  localparam logic [2:0] DESCARTE = 3'd3;
  localparam logic [2:0] DETENIDO = 3'd4;
  localparam logic [2:0] ERROR    = 3'd5;

  logic [2:0] r_Estado, w_Estado_sig;
  logic [7:0] r_PC, r_Espera, r_Dir_pend;
  logic [8:0] r_Instr;
  logic       r_Pend;
  logic       w_Fin_espera;

  // The cycle that would bring the counter to MAX_ESPERA is the last one allowed.
  assign w_Fin_espera = (r_Espera + 8'd1) == 8'(MAX_ESPERA);

  always_comb begin
    w_Estado_sig = r_Estado;
    case (r_Estado)
      REPOSO:            w_Estado_sig = i_Detener ? DETENIDO : SOLICITA;
      SOLICITA: begin
        if (i_Mem_ack)         w_Estado_sig = (i_Salto || r_Pend) ? DESCARTE : ENTREGA;
        else if (w_Fin_espera) w_Estado_sig = ERROR;
      end
      ENTREGA, DESCARTE: w_Estado_sig = i_Detener ? DETENIDO : SOLICITA;
      DETENIDO:          if (!i_Detener) w_Estado_sig = SOLICITA;
      ERROR:             w_Estado_sig = ERROR;
      default:           w_Estado_sig = ERROR;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Estado   <= REPOSO;
      r_PC       <= 8'd0;
      r_Instr    <= 9'h000;
      r_Espera   <= 8'd0;
      r_Pend     <= 1'b0;
      r_Dir_pend <= 8'd0;
    end else begin
      r_Estado <= w_Estado_sig;
      case (r_Estado)
        SOLICITA: begin
          if (i_Mem_ack) begin
            r_Espera <= 8'd0;
            r_Pend   <= 1'b0;
            // A jump seen during this fetch makes the returned word stale.
            if (i_Salto)     r_PC <= i_Dir_salto;
            else if (r_Pend) r_PC <= r_Dir_pend;
            else begin
              r_Instr <= i_Mem_dato;
              r_PC    <= r_PC + 8'd1;
            end
          end else begin
            r_Espera <= r_Espera + 8'd1;
            if (i_Salto) begin
              r_Pend     <= 1'b1;
              r_Dir_pend <= i_Dir_salto;
            end
          end
        end
        ENTREGA, DETENIDO: begin
          r_Espera <= 8'd0;
          if (i_Salto) r_PC <= i_Dir_salto;
        end
        default: r_Espera <= 8'd0;
      endcase
    end
  end

  // Decoded from the state register so reset removes the request without a clock.
  assign o_Mem_req     = (r_Estado == SOLICITA);
  assign o_Timming     = (r_Estado == ENTREGA);
  assign o_Error       = (r_Estado == ERROR);
  assign o_Mem_dir     = r_PC;
  assign o_PC          = r_PC;
  assign o_Instruccion = r_Instr;
endmodule
